// File: rtl/lsu_pkg.sv
// Shared types and encodings for the data-bus load/store unit.
// Holds the FSM state enum, SIZE codes, funct3 access codes and the funct3-to-SIZE mapping.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b11;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b00;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Reserved funct3 encodings fall through to a word access.
    function automatic logic [1:0] size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_of = SZ_BYTE;
            F3_H, F3_HU: size_of = SZ_HALF;
            default:     size_of = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and misalignment on the request side,
// load lane select and sign/zero extension on the captured-data side.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_wdata,
    output logic [1:0]  st_size,
    output logic [31:0] st_data,
    output logic        st_misaligned,
    input  logic [1:0]  ld_addr_lo,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_data_in,
    output logic [31:0] ld_data
);

    logic [31:0] byte_rep;
    logic [31:0] half_rep;
    logic [7:0]  ld_lanes_b [4];
    logic [15:0] ld_lanes_h [2];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        sign_en;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lanes
            assign byte_rep[8*gi +: 8]  = st_wdata[7:0];
            assign ld_lanes_b[gi]       = ld_data_in[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lanes
            assign half_rep[16*gi +: 16] = st_wdata[15:0];
            assign ld_lanes_h[gi]        = ld_data_in[16*gi +: 16];
        end
    endgenerate

    assign st_size = size_of(st_funct3);

    always_comb begin
        st_data       = st_wdata;
        st_misaligned = 1'b0;
        case (st_size)
            SZ_BYTE: st_data = byte_rep;
            SZ_HALF: begin
                st_data       = half_rep;
                st_misaligned = st_addr_lo[0];
            end
            default: st_misaligned = |st_addr_lo;
        endcase
    end

    assign ld_byte = ld_lanes_b[ld_addr_lo];
    assign ld_half = ld_lanes_h[ld_addr_lo[1]];
    // funct3[2] distinguishes the unsigned load variants.
    assign sign_en = ~ld_funct3[2];

    always_comb begin
        ld_data = ld_data_in;
        case (size_of(ld_funct3))
            SZ_BYTE: ld_data = {{24{sign_en & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{sign_en & ld_half[15]}}, ld_half};
            default: ld_data = ld_data_in;
        endcase
    end

endmodule

// File: rtl/data_bus_lsu.sv
// Load/store unit: latches a core memory request, runs one bus cycle with wait states
// and a timeout, stalls the core meanwhile, and presents extended load data in DONE.
module data_bus_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] DAD,
    output logic [31:0] ddt_out,
    output logic        ddt_oe,
    input  logic [31:0] ddt_in,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      dout_reg;
    logic [1:0]       size_reg;
    logic [2:0]       funct3_reg;
    logic             write_reg;
    logic [31:0]      rdata_reg;
    logic             mis_reg;
    logic             err_reg;

    logic        req_any;
    logic        timeout;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        st_mis;
    logic [31:0] ld_data;

    assign req_any = req_read | req_write;
    assign timeout = ACKD_n && (cnt_reg == CNT_LAST);

    lsu_align u_align (
        .st_addr_lo    (req_addr[1:0]),
        .st_funct3     (req_funct3),
        .st_wdata      (req_wdata),
        .st_size       (st_size),
        .st_data       (st_data),
        .st_misaligned (st_mis),
        .ld_addr_lo    (addr_reg[1:0]),
        .ld_funct3     (funct3_reg),
        .ld_data_in    (ddt_in),
        .ld_data       (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (req_any) state_next = st_mis ? DONE : BUS;
            BUS:  if (!ACKD_n || timeout) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, wait-state counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            addr_reg   <= '0;
            dout_reg   <= '0;
            size_reg   <= SZ_WORD;
            funct3_reg <= '0;
            write_reg  <= 1'b0;
            rdata_reg  <= '0;
            mis_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (req_any) begin
                        addr_reg   <= req_addr;
                        dout_reg   <= st_data;
                        size_reg   <= st_size;
                        funct3_reg <= req_funct3;
                        write_reg  <= req_write;
                        mis_reg    <= st_mis;
                        err_reg    <= 1'b0;
                        rdata_reg  <= '0;
                    end
                end
                BUS: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (!ACKD_n) begin
                        rdata_reg <= write_reg ? 32'd0 : ld_data;
                    end else if (timeout) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= '0;
                    end
                end
                DONE: begin
                    cnt_reg   <= '0;
                    rdata_reg <= '0;
                    mis_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    // Bus outputs are forced inactive outside BUS; results are only visible in DONE.
    always_comb begin
        stall      = 1'b0;
        MREQ       = 1'b0;
        WRITE      = 1'b0;
        ddt_oe     = 1'b0;
        DAD        = '0;
        SIZE       = SZ_WORD;
        ddt_out    = '0;
        rdata      = '0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        case (state_reg)
            IDLE: stall = req_any;
            BUS: begin
                stall   = 1'b1;
                MREQ    = 1'b1;
                WRITE   = write_reg;
                ddt_oe  = write_reg;
                DAD     = addr_reg;
                SIZE    = size_reg;
                ddt_out = dout_reg;
            end
            DONE: begin
                rdata      = rdata_reg;
                misaligned = mis_reg;
                bus_err    = err_reg;
            end
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_data_bus_lsu.sv
// Scoreboard bench for data_bus_lsu: expected results are queued at issue and
// compared when the access reaches DONE; bus signals are checked every BUS cycle.
module tb_data_bus_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        stall;
    logic [31:0] rdata;
    logic        misaligned, bus_err;
    logic [31:0] DAD, ddt_out, ddt_in;
    logic        ddt_oe, MREQ, WRITE, ACKD_n;
    logic [1:0]  SIZE;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    data_bus_lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .stall(stall), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .DAD(DAD), .ddt_out(ddt_out), .ddt_oe(ddt_oe), .ddt_in(ddt_in),
        .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // waits < 0 means ACKD_n never asserts (timeout path).
    task automatic do_access(input string name, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] f3, input int waits,
                             input logic [31:0] dval, input logic [1:0] exp_size,
                             input logic [31:0] exp_dout, input exp_t exp,
                             input int exp_bus);
        int   bus_n = 0;
        int   stall_n = 1;
        bit   done = 0;
        exp_t got_exp;
        @(negedge clk);
        req_read = ~wr; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_funct3 = f3; ddt_in = dval; ACKD_n = 1'b1;
        sb_q.push_back(exp);
        #1 check_eq({name, "_idle_stall"}, 32'(stall), 32'd1);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            req_read = 1'b0; req_write = 1'b0;
            ACKD_n = 1'b1;
            if (MREQ) begin
                bus_n++;
                if (stall) stall_n++;
                check_eq({name, "_dad"},   DAD, addr);
                check_eq({name, "_size"},  32'(SIZE), 32'(exp_size));
                check_eq({name, "_write"}, 32'(WRITE), 32'(wr));
                check_eq({name, "_oe"},    32'(ddt_oe), 32'(wr));
                if (wr) check_eq({name, "_dout"}, ddt_out, exp_dout);
                if (waits >= 0 && bus_n == waits + 1) ACKD_n = 1'b0;
            end else begin
                done = 1;
                check_eq({name, "_done_stall"}, 32'(stall), 32'd0);
                if (sb_q.size() == 0) begin
                    check_eq({name, "_sb_nonempty"}, 32'd0, 32'd1);
                end else begin
                    got_exp = sb_q.pop_front();
                    check_eq({name, "_rdata"}, rdata, got_exp.rdata);
                    check_eq({name, "_mis"},   32'(misaligned), 32'(got_exp.mis));
                    check_eq({name, "_err"},   32'(bus_err), 32'(got_exp.err));
                end
            end
        end
        if (!done) check_eq({name, "_done_bound"}, 32'd0, 32'd1);
        check_eq({name, "_mreq_cycles"},  32'(bus_n), 32'(exp_bus));
        check_eq({name, "_stall_cycles"}, 32'(stall_n), 32'(exp_bus + 1));
        $display("txn %s addr=0x%08h bus_cycles=%0d rdata=0x%08h mis=%0b err=%0b",
                 name, addr, bus_n, rdata, misaligned, bus_err);
    endtask

    exp_t e;
    int   rb;

    initial begin
        rst = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_funct3 = '0; ddt_in = '0; ACKD_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mreq",  32'(MREQ), 32'd0);
        check_eq("rst_write", 32'(WRITE), 32'd0);
        check_eq("rst_oe",    32'(ddt_oe), 32'd0);
        check_eq("rst_dad",   DAD, 32'd0);
        check_eq("rst_size",  32'(SIZE), 32'd0);
        check_eq("rst_dout",  ddt_out, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_flags", {30'd0, misaligned, bus_err}, 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        e = '{32'hDEADBEEF, 1'b0, 1'b0};
        do_access("lw_100", 1'b0, 32'h100, 0, 3'b010, 0, 32'hDEADBEEF, 2'b00, 0, e, 1);
        e = '{32'hFFFFFF80, 1'b0, 1'b0};
        do_access("lb_103", 1'b0, 32'h103, 0, 3'b000, 2, 32'h80123456, 2'b11, 0, e, 3);
        e = '{32'h00000080, 1'b0, 1'b0};
        do_access("lbu_103", 1'b0, 32'h103, 0, 3'b100, 2, 32'h80123456, 2'b11, 0, e, 3);
        e = '{32'h00000000, 1'b0, 1'b0};
        do_access("sh_202", 1'b1, 32'h202, 32'h00001234, 3'b001, 3, 32'hFFFFFFFF, 2'b01, 32'h12341234, e, 4);
        do_access("sb_001", 1'b1, 32'h001, 32'h000000AB, 3'b000, 1, 32'h0, 2'b11, 32'hABABABAB, e, 2);
        do_access("sw_010", 1'b1, 32'h010, 32'hCAFEF00D, 3'b010, 0, 32'h0, 2'b00, 32'hCAFEF00D, e, 1);
        e = '{32'hFFFF8001, 1'b0, 1'b0};
        do_access("lh_002", 1'b0, 32'h002, 0, 3'b001, 1, 32'h80017FFF, 2'b01, 0, e, 2);
        e = '{32'h00008001, 1'b0, 1'b0};
        do_access("lhu_002", 1'b0, 32'h002, 0, 3'b101, 0, 32'h80017FFF, 2'b01, 0, e, 1);
        e = '{32'h00007FFF, 1'b0, 1'b0};
        do_access("lh_000", 1'b0, 32'h000, 0, 3'b001, 0, 32'h80017FFF, 2'b01, 0, e, 1);
        e = '{32'h00000000, 1'b1, 1'b0};
        do_access("lw_101_mis", 1'b0, 32'h101, 0, 3'b010, 0, 32'h11111111, 2'b00, 0, e, 0);
        do_access("lh_201_mis", 1'b0, 32'h201, 0, 3'b001, 0, 32'h11111111, 2'b01, 0, e, 0);
        e = '{32'h76543210, 1'b0, 1'b0};
        do_access("f3_011_104", 1'b0, 32'h104, 0, 3'b011, 0, 32'h76543210, 2'b00, 0, e, 1);
        e = '{32'h00000000, 1'b0, 1'b1};
        do_access("lw_300_tmo", 1'b0, 32'h300, 0, 3'b010, -1, 32'h5555AAAA, 2'b00, 0, e, 16);
        e = '{32'h5555AAAA, 1'b0, 1'b0};
        do_access("lw_300_edge", 1'b0, 32'h300, 0, 3'b010, 15, 32'h5555AAAA, 2'b00, 0, e, 16);

        // Reset asserted during the third BUS cycle of a stuck load.
        @(negedge clk);
        req_read = 1'b1; req_addr = 32'h400; req_funct3 = 3'b010; ACKD_n = 1'b1;
        rb = 0;
        for (int c = 0; c < 10 && rb < 3; c++) begin
            @(negedge clk);
            req_read = 1'b0;
            if (MREQ) rb++;
        end
        check_eq("rst_mid_reached", 32'(rb), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_mreq",  32'(MREQ), 32'd0);
        check_eq("rst_mid_oe",    32'(ddt_oe), 32'd0);
        check_eq("rst_mid_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        req_read = 1'b1;
        #1 check_eq("rst_mid_stall_req", 32'(stall), 32'd1);
        req_read = 1'b0;
        #1 check_eq("rst_mid_stall_noreq", 32'(stall), 32'd0);
        $display("txn rst_mid addr=0x00000400 bus_cycles=%0d", rb);

        e = '{32'h0BADF00D, 1'b0, 1'b0};
        do_access("lw_after_rst", 1'b0, 32'h404, 0, 3'b010, 1, 32'h0BADF00D, 2'b00, 0, e, 2);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_lsu.md
Name: data_bus_lsu

Overview:
- Load/store unit between the single-cycle RV32I core and the external data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Latches the core's load/store request and runs a bus cycle with wait states until ACKD_n is sampled low.
- Stalls the core (freezes PC and register write) for the whole transaction.
- Steers byte lanes on stores, and extracts and sign/zero-extends load data before it reaches the register write-back mux.

Parameters:
- TIMEOUT_CYCLES, 16: maximum BUS-state cycles without ACKD_n low before the transfer is aborted with bus_err.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- req_read  input  1  core load request (decoder mem_read)
- req_write  input  1  core store request (decoder mem_write)
- req_addr  input  32  effective address (ALU result)
- req_wdata  input  32  store data (rs2)
- req_funct3  input  3  access type (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU)
- stall  output  1  high = core must hold state this cycle
- rdata  output  32  extended load data, valid in DONE
- misaligned  output  1  one-cycle pulse in DONE for a misaligned access
- bus_err  output  1  one-cycle pulse in DONE on timeout
- DAD  output  32  bus address
- ddt_out  output  32  bus write data (top level drives DDT = ddt_oe ? ddt_out : 'z)
- ddt_oe  output  1  DDT drive enable
- ddt_in  input  32  DDT sampled value
- MREQ  output  1  bus request
- WRITE  output  1  1 = write cycle
- SIZE  output  2  11 byte, 01 half, 00 word
- ACKD_n  input  1  active-low transfer acknowledge

Behaviour:
- Clock and reset: one clock clk. rst is synchronous and active-high. Reset puts the FSM in IDLE and clears the counter.
- Outputs after reset: MREQ=0, WRITE=0, ddt_oe=0, DAD=0, SIZE=00, ddt_out=0, rdata=0, misaligned=0, bus_err=0, stall=0.
- Reset mid-transfer: the FSM returns to IDLE on the next edge and MREQ drops that same edge.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - stall = req_read|req_write (combinational).
  - On a request, latch addr/wdata/funct3 and direction (write wins if both are high).
  - Aligned access → BUS. Misaligned (half with addr[0]=1, word with addr[1:0]≠0) → DONE with misaligned set and no bus cycle.
- BUS:
  - MREQ=1; WRITE, SIZE, DAD and ddt_out are registered and held stable for the whole state.
  - ddt_oe = WRITE.
  - stall=1. Counter increments each cycle.
  - ACKD_n sampled 0 → capture ddt_in (reads only), go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with ACKD_n=1 → bus_err set, rdata=0, go to DONE.
  - ACKD_n on the same edge as the timeout: the ack wins.
- DONE (exactly one cycle):
  - stall=0; MREQ=0; rdata, misaligned and bus_err valid.
  - The request inputs are ignored.
  - Next state is IDLE, so back-to-back memory instructions each take a fresh IDLE cycle.
- Latency: with a request in IDLE at cycle t, MREQ rises at t+1. An ack sampled in the first BUS cycle gives DONE at t+2. Minimum 3 stalled-or-done cycles per access. Each wait state adds 1.
- Store lane steering (little-endian):
  - Byte: ddt_out = {4{wdata[7:0]}}.
  - Half: ddt_out = {2{wdata[15:0]}}.
  - Word: ddt_out = wdata.
- Load extraction:
  - Byte lane = ddt_in[8*addr[1:0]+:8]; half lane = ddt_in[16*addr[1]+:16].
  - funct3[2]=0 → sign-extend; funct3[2]=1 → zero-extend.
- Unused funct3 values (011, 110, 111) are treated as word accesses, SIZE=00.
- Non-memory cycles: no state change, all bus outputs inactive.

Decomposition:
- Shared package lsu_pkg:
  - state enum {IDLE, BUS, DONE}
  - SIZE constants SZ_BYTE=2'b11, SZ_HALF=2'b01, SZ_WORD=2'b00
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
- One combinational sub-module lsu_align: store lane replication, load lane select/extend and misalignment detect. The FSM, counter and bus registers stay in data_bus_lsu.

Test Plan:
- LW 0x100, ACKD_n low in first BUS cycle, ddt_in=0xDEADBEEF → MREQ high 1 cycle, SIZE=00, DONE rdata=0xDEADBEEF, stall high 2 cycles.
- LB 0x103 with ddt_in=0x80123456 and 2 wait states → rdata=0xFFFFFF80; LBU at the same address → 0x00000080; stall high 4 cycles.
- SH 0x202 with wdata=0x00001234 → DAD=0x202, SIZE=01, WRITE=1, ddt_oe=1, ddt_out=0x12341234 held stable until ack.
- LW 0x101 → MREQ never asserted, misaligned pulses 1 cycle, stall high exactly 1 cycle.
- LW 0x300, ACKD_n stuck high, TIMEOUT_CYCLES=16 → MREQ high 16 cycles, then bus_err pulse with rdata=0; ack and timeout on the same edge → bus_err=0, data captured.
- rst asserted in the 3rd BUS cycle → next edge: MREQ=0, ddt_oe=0, stall follows the request inputs from IDLE; a new LW completes normally.
